// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with
// valid/ready handshakes on both sides and occupancy reporting.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          wr_vld_i,
    output logic                          wr_rdy_o,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_rdy_i,
    output logic                          rd_vld_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DATA_DEPTH):0]   elem_cnt_o
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         cnt;
    logic                  push;
    logic                  pop;

    // Extra wrap bit lets the pointer difference span 0..DATA_DEPTH.
    assign cnt        = wr_ptr - rd_ptr;
    assign elem_cnt_o = cnt;
    assign full_o     = (cnt == DEPTH_C);
    assign empty_o    = (cnt == '0);
    assign wr_rdy_o   = !full_o;
    assign rd_vld_o   = !empty_o;

    assign push = wr_vld_i && wr_rdy_o;
    assign pop  = rd_rdy_i && rd_vld_o;

    assign rd_data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard-driven bench for sync_fifo
// (DATA_DEPTH=8, DATA_WIDTH=32).
module tb_sync_fifo;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wr_vld_i;
    logic        wr_rdy_o;
    logic [31:0] wr_data_i;
    logic        rd_rdy_i;
    logic        rd_vld_o;
    logic [31:0] rd_data_o;
    logic        full_o;
    logic        empty_o;
    logic [3:0]  elem_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int mc       = 0;
    logic [31:0] exp_q [$];

    sync_fifo #(.DATA_WIDTH(32), .DATA_DEPTH(8)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .wr_vld_i   (wr_vld_i),
        .wr_rdy_o   (wr_rdy_o),
        .wr_data_i  (wr_data_i),
        .rd_rdy_i   (rd_rdy_i),
        .rd_vld_o   (rd_vld_o),
        .rd_data_o  (rd_data_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .elem_cnt_o (elem_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Drives one clock of stimulus; samples head data before the edge
    // and updates the reference model. Comparisons live in the tests.
    task automatic cycle(input logic wv, input logic [31:0] wd,
                         input logic rr, output logic popped,
                         output logic [31:0] seen, output logic [31:0] exp);
        logic pushed;
        wr_vld_i  = wv;
        wr_data_i = wd;
        rd_rdy_i  = rr;
        seen   = rd_data_o;
        popped = rr && (mc != 0);
        pushed = wv && (mc != 8);
        exp    = 32'd0;
        if (popped) exp = exp_q.pop_front();
        if (pushed) exp_q.push_back(wd);
        @(posedge clk_i);
        #1;
        mc = mc + int'(pushed) - int'(popped);
        wr_vld_i = 1'b0;
        rd_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        wr_vld_i = 1'b0;
        rd_rdy_i = 1'b0;
        wr_data_i = 32'd0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty: got %b want 1", empty_o);
        end
        n_checks++;
        if (full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full: got %b want 0", full_o);
        end
        n_checks++;
        if (elem_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", elem_cnt_o);
        end
        n_checks++;
        if (wr_rdy_o !== 1'b1 || rd_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: got wr_rdy=%b rd_vld=%b want 1 0",
                     wr_rdy_o, rd_vld_o);
        end
        n_checks++;
        if (rd_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h want 0", rd_data_o);
        end
    endtask

    task automatic test_pop_empty();
        logic p;
        logic [31:0] s, e;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'd0, 1'b1, p, s, e);
            n_checks++;
            if (rd_vld_o !== 1'b0 || elem_cnt_o !== 4'd0) begin
                n_fail++;
                $display("FAIL pop_empty: got vld=%b cnt=%0d want 0 0",
                         rd_vld_o, elem_cnt_o);
            end
        end
    endtask

    task automatic test_fill();
        logic p;
        logic [31:0] s, e;
        logic [3:0] want;
        for (int v = 5; v <= 14; v++) begin
            cycle(1'b1, 32'(v), 1'b0, p, s, e);
            want = (v <= 12) ? 4'(v - 4) : 4'd8;
            n_checks++;
            if (elem_cnt_o !== want) begin
                n_fail++;
                $display("FAIL fill_cnt[%0d]: got %0d want %0d",
                         v, elem_cnt_o, want);
            end
            if (v >= 12) begin
                n_checks++;
                if (full_o !== 1'b1 || wr_rdy_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_full[%0d]: got full=%b rdy=%b want 1 0",
                             v, full_o, wr_rdy_o);
                end
            end
        end
    endtask

    task automatic test_drain_three();
        logic p;
        logic [31:0] s, e;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'd0, 1'b1, p, s, e);
            n_checks++;
            if (!p || s !== e || s !== 32'(5 + i)) begin
                n_fail++;
                $display("FAIL drain3[%0d]: got %0d want %0d", i, s, 5 + i);
            end
        end
        n_checks++;
        if (elem_cnt_o !== 4'd5 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain3_status: got cnt=%0d full=%b want 5 0",
                     elem_cnt_o, full_o);
        end
    endtask

    task automatic test_simul_wrap();
        logic p;
        logic [31:0] s, e;
        cycle(1'b1, 32'd23, 1'b1, p, s, e);
        n_checks++;
        if (s !== e || s !== 32'd8 || elem_cnt_o !== 4'd5) begin
            n_fail++;
            $display("FAIL simul_23: got data=%0d cnt=%0d want 8 5",
                     s, elem_cnt_o);
        end
        cycle(1'b1, 32'd45, 1'b1, p, s, e);
        n_checks++;
        if (s !== e || s !== 32'd9 || elem_cnt_o !== 4'd5) begin
            n_fail++;
            $display("FAIL simul_45: got data=%0d cnt=%0d want 9 5",
                     s, elem_cnt_o);
        end
    endtask

    task automatic test_final_drain();
        logic p;
        logic [31:0] s, e;
        logic [31:0] want [5];
        want = '{32'd10, 32'd11, 32'd12, 32'd23, 32'd45};
        for (int i = 0; i < 7; i++) begin
            if (i >= 5) begin
                n_checks++;
                if (rd_vld_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL final_idle_vld[%0d]: got %b want 0",
                             i, rd_vld_o);
                end
            end
            cycle(1'b0, 32'd0, 1'b1, p, s, e);
            if (i < 5) begin
                n_checks++;
                if (!p || s !== e || s !== want[i]) begin
                    n_fail++;
                    $display("FAIL final_drain[%0d]: got %0d want %0d",
                             i, s, want[i]);
                end
            end
        end
        n_checks++;
        if (empty_o !== 1'b1 || rd_vld_o !== 1'b0 || rd_data_o !== 32'd0
            || elem_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL final_empty: got e=%b v=%b d=%0h c=%0d want 1 0 0 0",
                     empty_o, rd_vld_o, rd_data_o, elem_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic p;
        logic [31:0] s, e;
        cycle(1'b1, 32'h100, 1'b0, p, s, e);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b1, p, s, e);
            n_checks++;
            if (!p || s !== e || s !== 32'h100 + 32'(i - 1)
                || elem_cnt_o !== 4'd1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %0h cnt=%0d want %0h 1",
                         i, s, elem_cnt_o, 32'h100 + 32'(i - 1));
            end
        end
        cycle(1'b0, 32'd0, 1'b1, p, s, e);
        n_checks++;
        if (s !== 32'h10c || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_tail: got %0h empty=%b want 10c 1",
                     s, empty_o);
        end
    endtask

    task automatic test_async_reset();
        logic p;
        logic [31:0] s, e;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(60 + i), 1'b0, p, s, e);
        #2;
        rstn_i = 1'b0;
        #1;
        exp_q.delete();
        mc = 0;
        n_checks++;
        if (empty_o !== 1'b1 || full_o !== 1'b0 || elem_cnt_o !== 4'd0
            || wr_rdy_o !== 1'b1 || rd_vld_o !== 1'b0
            || rd_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got e=%b f=%b c=%0d r=%b v=%b d=%0h want 1 0 0 1 0 0",
                     empty_o, full_o, elem_cnt_o, wr_rdy_o, rd_vld_o,
                     rd_data_o);
        end
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        cycle(1'b1, 32'd77, 1'b0, p, s, e);
        cycle(1'b0, 32'd0, 1'b1, p, s, e);
        n_checks++;
        if (!p || s !== e || s !== 32'd77 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got %0d empty=%b want 77 1",
                     s, empty_o);
        end
    endtask

    initial begin
        test_reset();
        test_pop_empty();
        test_fill();
        test_drain_three();
        test_simul_wrap();
        test_final_drain();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
